// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle ops and iterative shift-add multiply / restoring divide
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             dbz,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, b_q;
  logic div_q, c_f, v_f, z_f, d_f, i_f;
  logic multi, accept;
  logic [WIDTH:0] add_w, sub_w, mul_w, div_r;
  logic [WIDTH-1:0] s_lo, s_hi, mul_hi, mul_lo, div_hi, div_lo, st_hi, st_lo;
  logic s_c, s_v, s_d, s_i, div_ge;
  assign accept = in_valid && in_ready;
  assign multi  = opcode == 4'd8 || (opcode == 4'd9 && B != '0);
  assign add_w  = {1'b0, A} + {1'b0, B};
  assign sub_w  = {1'b0, A} - {1'b0, B};
  always_comb begin
    s_lo = '0;
    s_hi = '0;
    s_c  = 1'b0;
    s_v  = 1'b0;
    s_d  = 1'b0;
    s_i  = 1'b0;
    case (opcode)
      4'd0: {s_c, s_lo} = add_w;
      4'd1: begin
        s_lo = add_w[WIDTH-1:0];
        s_v  = A[WIDTH-1] == B[WIDTH-1] && s_lo[WIDTH-1] != A[WIDTH-1];
      end
      4'd2: {s_c, s_lo} = sub_w;
      4'd3: begin
        s_lo = sub_w[WIDTH-1:0];
        s_v  = A[WIDTH-1] != B[WIDTH-1] && s_lo[WIDTH-1] != A[WIDTH-1];
      end
      4'd4: s_lo = A & B;
      4'd5: s_lo = A | B;
      4'd6: s_lo = A ^ B;
      4'd7: s_lo = A >> 1;
      4'd8: s_lo = '0;
      4'd9: begin
        s_lo = B == '0 ? '1 : '0;
        s_hi = B == '0 ? A : '0;
        s_d  = B == '0;
      end
      default: s_i = 1'b1;
    endcase
  end
  // {hi,lo} is the product register while multiplying and {remainder,quotient} while dividing
  assign mul_w  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
  assign mul_hi = mul_w[WIDTH:1];
  assign mul_lo = {mul_w[0], lo[WIDTH-1:1]};
  assign div_r  = {hi, lo[WIDTH-1]};
  assign div_ge = div_r >= {1'b0, b_q};
  assign div_hi = div_ge ? WIDTH'(div_r - {1'b0, b_q}) : div_r[WIDTH-1:0];
  assign div_lo = {lo[WIDTH-2:0], div_ge};
  assign st_hi  = div_q ? div_hi : mul_hi;
  assign st_lo  = div_q ? div_lo : mul_lo;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? (multi ? BUSY : DONE) : IDLE;
      BUSY:    state_n = cnt == CW'(WIDTH - 1) ? DONE : BUSY;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      {c_f, v_f, z_f, d_f, i_f} <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt   <= '0;
        b_q   <= B;
        div_q <= opcode[0];
        hi    <= multi ? '0 : s_hi;
        lo    <= multi ? A : s_lo;
        {c_f, v_f, d_f, i_f} <= {s_c, s_v, s_d, s_i};
        z_f   <= s_lo == '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CW'(1);
        hi  <= st_hi;
        lo  <= st_lo;
        z_f <= div_q ? st_lo == '0 : {st_hi, st_lo} == '0;
      end
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign result    = out_valid ? lo : '0;
  assign result_hi = out_valid ? hi : '0;
  assign carryout  = out_valid && c_f;
  assign overflow  = out_valid && v_f;
  assign zero      = out_valid && z_f;
  assign dbz       = out_valid && d_f;
  assign illegal   = out_valid && i_f;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed literal cases plus randomized traffic against a behavioural model of seq_alu
module tb_seq_alu;
  localparam int W = 8;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] A = 0, B = 0;
  logic [3:0] opcode = 0;
  logic in_ready, out_valid, carryout, overflow, zero, dbz, illegal;
  logic [W-1:0] result, result_hi;
  int total = 0, bad = 0, done_cnt = 0;
  int ph = 0, left = 0, e_lat = 1;
  logic [W-1:0] e_res, e_hi;
  logic e_c, e_v, e_z, e_d, e_i;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .carryout(carryout), .overflow(overflow),
    .zero(zero), .dbz(dbz), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, t;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p = 0;
    t = 0;
    {e_res, e_hi, e_c, e_v, e_d, e_i} = '0;
    e_lat = 1;
    case (op)
      4'd0: begin t = a + b; e_res = t[W-1:0]; e_c = t[W]; end
      4'd1: begin t = sa + sb; e_res = t[W-1:0]; e_v = t > 2**(W-1) - 1 || t < -(2**(W-1)); end
      4'd2: begin t = a - b; e_res = t[W-1:0]; e_c = a < b; end
      4'd3: begin t = sa - sb; e_res = t[W-1:0]; e_v = t > 2**(W-1) - 1 || t < -(2**(W-1)); end
      4'd4: e_res = a & b;
      4'd5: e_res = a | b;
      4'd6: e_res = a ^ b;
      4'd7: e_res = a >> 1;
      4'd8: begin p = a * b; e_res = p[W-1:0]; e_hi = p[2*W-1:W]; e_lat = W + 1; end
      4'd9: begin
        if (b == 0) begin e_res = '1; e_hi = a; e_d = 1; end
        else begin e_res = a / b; e_hi = a % b; e_lat = W + 1; end
      end
      default: e_i = 1;
    endcase
    e_z = op == 4'd8 ? p == 0 : e_res == 0;
  endtask

  // reference: ph 0 = waiting for an operation, 1 = computing, 2 = result presented
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) ph = 0;
    else if (ph == 0) begin
      if (in_valid) begin
        model(opcode, A, B);
        left = e_lat - 1;
        ph = left == 0 ? 2 : 1;
      end
    end else if (ph == 1) begin
      left--;
      if (left == 0) ph = 2;
    end else if (out_ready) begin
      ph = 0;
      done_cnt++;
    end
  end

  always @(negedge clk) if (reset) begin
    chk("in_ready", in_ready, ph == 0);
    chk("out_valid", out_valid, ph == 2);
    if (ph == 2) begin
      chk("m_result", result, e_res);
      chk("m_result_hi", result_hi, e_hi);
      chk("m_flags", {carryout, overflow, zero, dbz, illegal}, {e_c, e_v, e_z, e_d, e_i});
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input logic [W-1:0] r, input logic [W-1:0] rh,
                        input logic [4:0] fl, input int hold);
    int n;
    @(posedge clk); #1;
    in_valid = 1; opcode = op; A = a; B = b; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; A = pick(); B = pick(); opcode = 4'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 40);
    chk("latency", n, lat);
    chk("result", result, r);
    chk("result_hi", result_hi, rh);
    chk("flags", {carryout, overflow, zero, dbz, illegal}, fl);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_result", result, r);
      chk("hold_flags", {carryout, overflow, zero, dbz, illegal}, fl);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {result, result_hi, carryout, overflow, zero, dbz, illegal}, 0);
    reset = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    run_op(4'd0, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 5'b10100, 0);
    run_op(4'd3, 8'hC0, 8'h41, 1, 8'h7F, 8'h00, 5'b01000, 0);
    run_op(4'd2, 8'h0F, 8'h1F, 1, 8'hF0, 8'h00, 5'b10000, 0);
    run_op(4'd8, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 5'b00000, 0);
    run_op(4'd9, 8'h64, 8'h07, 9, 8'h0E, 8'h02, 5'b00000, 0);
    run_op(4'd9, 8'h5A, 8'h00, 1, 8'hFF, 8'h5A, 5'b00010, 0);
    run_op(4'd6, 8'hA5, 8'h3C, 1, 8'h99, 8'h00, 5'b00000, 5);
    run_op(4'hC, 8'h12, 8'h34, 1, 8'h00, 8'h00, 5'b00101, 0);
    run_op(4'd7, 8'hFF, 8'h00, 1, 8'h7F, 8'h00, 5'b00000, 0);
    run_op(4'd1, 8'h7F, 8'h01, 1, 8'h80, 8'h00, 5'b01000, 0);
    run_op(4'd8, 8'h00, 8'hFF, 9, 8'h00, 8'h00, 5'b00100, 0);
    // abort a multiply part-way through with an asynchronous reset
    @(posedge clk); #1;
    in_valid = 1; opcode = 4'd8; A = 8'hFF; B = 8'hFF;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (4) @(negedge clk);
    reset = 0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_outputs", {result, result_hi, carryout, overflow, zero, dbz, illegal}, 0);
    repeat (2) @(negedge clk);
    chk("abort_still_low", out_valid, 0);
    in_valid = 1; opcode = 4'd0; A = 8'h01; B = 8'h01;
    reset = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_result", result, 8'h02);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    done_cnt = 0;
    repeat (3000) begin
      @(posedge clk); #1;
      in_valid = $urandom_range(0, 1) == 1;
      opcode = $urandom_range(0, 3) == 0 ? 4'(8 + $urandom_range(0, 1)) : 4'($urandom);
      A = pick();
      B = pick();
      out_ready = $urandom_range(0, 2) != 0;
    end
    @(posedge clk); #1;
    in_valid = 0;
    chk("random_ops_completed", done_cnt > 100, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
